// File: rtl/williams_blt_mem_port.sv
// Blitter-side RAM port: negotiates 6809 HALT, then runs blitter reads, writes and nibble RMW.
// Strobes are registered; blt_ack holds until an E-phase enable so the blitter never misses it.
module williams_blt_mem_port #(
    parameter int RD_LATENCY = 1,
    parameter int HALT_SYNC  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_e_n,
    input  logic        halt,
    output logic        halt_ack,
    output logic        cpu_halt_n,
    input  logic        cpu_ba,
    input  logic        cpu_bs,
    input  logic        blt_rd,
    input  logic        blt_wr,
    input  logic [15:0] blt_address,
    input  logic [7:0]  blt_wdata,
    input  logic [1:0]  blt_nibble_en,
    output logic        blt_ack,
    output logic [7:0]  blt_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        HALT_REQ,
        OWNED,
        RD,
        RD_WAIT,
        WR,
        ACK
    } state_t;

    localparam logic [1:0] GRANT_TARGET = (HALT_SYNC != 0) ? 2'd2 : 2'd1;
    localparam logic [2:0] LAT          = 3'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  lat_q, lat_d;
    logic        settle_q, settle_d;
    logic        rmw_q, rmw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [1:0]  nib_q, nib_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  blt_rdata_q, blt_rdata_d;
    logic        cpu_halt_n_q, cpu_halt_n_d;
    logic        halt_ack_q, halt_ack_d;
    logic        blt_ack_q, blt_ack_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lat_d       = lat_q;
        settle_d    = settle_q;
        rmw_d       = rmw_q;
        wdata_d     = wdata_q;
        nib_d       = nib_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        blt_rdata_d = blt_rdata_q;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALT_REQ;
                end
            end
            HALT_REQ: begin
                if (!halt) begin
                    state_d = IDLE;
                    grant_d = 2'd0;
                end else if (en_e_n) begin
                    // Any E cycle without a full grant restarts the qualification.
                    if (cpu_ba && cpu_bs) begin
                        if (grant_q + 2'd1 == GRANT_TARGET) begin
                            state_d = OWNED;
                            grant_d = 2'd0;
                        end else begin
                            grant_d = grant_q + 2'd1;
                        end
                    end else begin
                        grant_d = 2'd0;
                    end
                end
            end
            OWNED: begin
                settle_d = 1'b0;
                if (!halt) begin
                    state_d = IDLE;
                end else if (!settle_q) begin
                    if (blt_rd) begin
                        mem_addr_d = blt_address;
                        rmw_d      = 1'b0;
                        state_d    = RD;
                    end else if (blt_wr) begin
                        mem_addr_d = blt_address;
                        wdata_d    = blt_wdata;
                        nib_d      = blt_nibble_en;
                        rmw_d      = 1'b1;
                        case (blt_nibble_en)
                            2'b11: begin
                                mem_wdata_d = blt_wdata;
                                state_d     = WR;
                            end
                            2'b00:   state_d = ACK;
                            default: state_d = RD;
                        endcase
                    end
                end
            end
            RD: begin
                lat_d   = 3'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == LAT) begin
                    if (rmw_q) begin
                        mem_wdata_d = {nib_q[1] ? wdata_q[7:4] : mem_rdata[7:4],
                                       nib_q[0] ? wdata_q[3:0] : mem_rdata[3:0]};
                        state_d     = WR;
                    end else begin
                        blt_rdata_d = mem_rdata;
                        state_d     = ACK;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            WR: begin
                state_d = ACK;
            end
            ACK: begin
                // The blitter moves on at this E edge; skip one clk before looking at it again.
                if (en_e_n) begin
                    state_d  = OWNED;
                    settle_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_halt_n_d = (state_d == IDLE);
        halt_ack_d   = state_d inside {OWNED, RD, RD_WAIT, WR, ACK};
        blt_ack_d    = (state_d == ACK);
        mem_rd_d     = (state_d == RD);
        mem_wr_d     = (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            lat_q        <= 3'd0;
            settle_q     <= 1'b0;
            rmw_q        <= 1'b0;
            wdata_q      <= 8'd0;
            nib_q        <= 2'd0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 8'd0;
            blt_rdata_q  <= 8'd0;
            cpu_halt_n_q <= 1'b1;
            halt_ack_q   <= 1'b0;
            blt_ack_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lat_q        <= lat_d;
            settle_q     <= settle_d;
            rmw_q        <= rmw_d;
            wdata_q      <= wdata_d;
            nib_q        <= nib_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            blt_rdata_q  <= blt_rdata_d;
            cpu_halt_n_q <= cpu_halt_n_d;
            halt_ack_q   <= halt_ack_d;
            blt_ack_q    <= blt_ack_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign cpu_halt_n = cpu_halt_n_q;
    assign halt_ack   = halt_ack_q;
    assign blt_ack    = blt_ack_q;
    assign blt_rdata  = blt_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_williams_blt_mem_port.sv
// Directed bench: scoreboard of expected RAM strobes plus a latency-accurate RAM model.
module tb_williams_blt_mem_port;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_e_n = 1'b0;
    logic        halt = 1'b0;
    logic        halt_ack;
    logic        cpu_halt_n;
    logic        cpu_ba = 1'b0;
    logic        cpu_bs = 1'b0;
    logic        blt_rd = 1'b0;
    logic        blt_wr = 1'b0;
    logic [15:0] blt_address = 16'd0;
    logic [7:0]  blt_wdata = 8'd0;
    logic [1:0]  blt_nibble_en = 2'd0;
    logic        blt_ack;
    logic [7:0]  blt_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'hEE;

    williams_blt_mem_port #(.RD_LATENCY(RD_LAT), .HALT_SYNC(1)) dut (
        .clk(clk), .rst_n(rst_n), .en_e_n(en_e_n), .halt(halt), .halt_ack(halt_ack),
        .cpu_halt_n(cpu_halt_n), .cpu_ba(cpu_ba), .cpu_bs(cpu_bs), .blt_rd(blt_rd),
        .blt_wr(blt_wr), .blt_address(blt_address), .blt_wdata(blt_wdata),
        .blt_nibble_en(blt_nibble_en), .blt_ack(blt_ack), .blt_rdata(blt_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    op_t        sb[$];
    op_t        op;
    logic [7:0] ram [0:65535];
    logic [7:0] rd_pipe = 8'd0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // RAM model and strobe scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {14'd0, mem_wr, mem_rd, mem_addr}, 32'd0);
            end else begin
                op = sb.pop_front();
                check("strobe_kind", {30'd0, mem_wr, mem_rd}, op.wr ? 32'd2 : 32'd1);
                check("strobe_addr", 32'(mem_addr), 32'(op.addr));
                if (op.wr) check("wr_data", 32'(mem_wdata), 32'(op.data));
            end
            if (mem_wr) ram[mem_addr] = mem_wdata;
        end
        rd_pipe   = {rd_pipe[6:0], mem_rd};
        mem_rdata = rd_pipe[RD_LAT] ? ram[mem_addr] : 8'hEE;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        en_e_n = (cyc % 4 == 3);
    endtask

    task automatic wait_en();
        while (!en_e_n) step();
    endtask

    task automatic push(input logic wr, input logic [15:0] addr, input logic [7:0] data);
        op_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [1:0] nib,
                             output logic [7:0] rd_o);
        bit done = 0;
        bit prev_hold = 0;
        int n = 0;
        blt_rd = rd; blt_wr = wr; blt_address = addr; blt_wdata = wdata; blt_nibble_en = nib;
        step();
        blt_address = ~addr; blt_wdata = ~wdata; blt_nibble_en = ~nib;
        while (!done && n < 100) begin
            if (prev_hold) check("ack_hold", 32'(blt_ack), 32'd1);
            prev_hold = 0;
            if (blt_ack) begin
                if (en_e_n) begin
                    step();
                    check("ack_drop", 32'(blt_ack), 32'd0);
                    step();
                    blt_rd = 1'b0; blt_wr = 1'b0;
                    done = 1;
                end else begin
                    prev_hold = 1;
                end
            end
            if (!done) begin
                step();
                n++;
            end
        end
        if (!done) begin
            check("ack_timeout", 32'(blt_ack), 32'd1);
            blt_rd = 1'b0; blt_wr = 1'b0;
        end
        check("halt_ack_held", 32'(halt_ack), 32'd1);
        rd_o = blt_rdata;
    endtask

    initial begin
        logic [7:0] rdv;
        int n;

        repeat (3) step();
        check("rst_cpu_halt_n", 32'(cpu_halt_n), 32'd1);
        check("rst_outs", {blt_rdata, mem_wdata, 9'd0, halt_ack, blt_ack, mem_rd, mem_wr},
              32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Halt negotiation: first E cycle no grant, then two qualifying E cycles.
        halt = 1'b1;
        step();
        check("halt_req_cpu_halt_n", 32'(cpu_halt_n), 32'd0);
        wait_en(); step();
        check("no_grant_no_ack", 32'(halt_ack), 32'd0);
        cpu_ba = 1'b1; cpu_bs = 1'b1;
        wait_en(); step();
        check("one_grant_no_ack", 32'(halt_ack), 32'd0);
        wait_en(); step();
        check("two_grants_ack", 32'(halt_ack), 32'd1);
        cpu_ba = 1'b0; cpu_bs = 1'b0;

        ram[16'h9A3C] = 8'h5E;
        push(1'b0, 16'h9A3C, 8'h00);
        do_access(1'b1, 1'b0, 16'h9A3C, 8'h00, 2'b00, rdv);
        check("read_data", 32'(rdv), 32'h5E);

        push(1'b1, 16'h0010, 8'hA7);
        do_access(1'b0, 1'b1, 16'h0010, 8'hA7, 2'b11, rdv);
        check("full_wr_ram", 32'(ram[16'h0010]), 32'hA7);
        check("rdata_hold", 32'(rdv), 32'h5E);

        ram[16'h0020] = 8'h3C;
        push(1'b0, 16'h0020, 8'h00);
        push(1'b1, 16'h0020, 8'hAC);
        do_access(1'b0, 1'b1, 16'h0020, 8'hA7, 2'b10, rdv);
        ram[16'h0021] = 8'h3C;
        push(1'b0, 16'h0021, 8'h00);
        push(1'b1, 16'h0021, 8'h37);
        do_access(1'b0, 1'b1, 16'h0021, 8'hA7, 2'b01, rdv);
        check("rmw_lo_ram", 32'(ram[16'h0021]), 32'h37);

        ram[16'h0022] = 8'h66;
        do_access(1'b0, 1'b1, 16'h0022, 8'hA7, 2'b00, rdv);
        check("nib00_ram", 32'(ram[16'h0022]), 32'h66);

        ram[16'h0030] = 8'h5A;
        push(1'b0, 16'h0030, 8'h00);
        do_access(1'b1, 1'b1, 16'h0030, 8'hFF, 2'b11, rdv);
        check("rd_priority_data", 32'(rdv), 32'h5A);
        check("rd_priority_ram", 32'(ram[16'h0030]), 32'h5A);

        halt = 1'b0;
        step();
        check("release_halt_ack", 32'(halt_ack), 32'd0);
        check("release_cpu_halt_n", 32'(cpu_halt_n), 32'd1);
        step();

        // Reacquire; an interrupted grant must restart the count.
        halt = 1'b1;
        step();
        cpu_ba = 1'b1; cpu_bs = 1'b1;
        wait_en(); step();
        cpu_ba = 1'b0;
        wait_en(); step();
        cpu_ba = 1'b1;
        wait_en(); step();
        check("grant_cleared", 32'(halt_ack), 32'd0);
        wait_en(); step();
        check("reacquire_ack", 32'(halt_ack), 32'd1);

        // Reset in the middle of an RMW read wait.
        ram[16'h0040] = 8'h11;
        push(1'b0, 16'h0040, 8'h00);
        blt_wr = 1'b1; blt_address = 16'h0040; blt_wdata = 8'hA7; blt_nibble_en = 2'b10;
        n = 0;
        while (!mem_rd && n < 20) begin
            step();
            n++;
        end
        check("rmw_rd_seen", 32'(mem_rd), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        check("midrst_cpu_halt_n", 32'(cpu_halt_n), 32'd1);
        check("midrst_outs", {blt_rdata, mem_wdata, 9'd0, halt_ack, blt_ack, mem_rd, mem_wr},
              32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        blt_wr = 1'b0; halt = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("midrst_ram_untouched", 32'(ram[16'h0040]), 32'h11);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/williams_blt_mem_port.md
Name: williams_blt_mem_port

Overview:
- Bus-side stage directly downstream of the blitter; consumes its halt/read/write requests and drives the byte-wide video/system RAM.
- Negotiates CPU halt: drives 6809 HALT, waits for bus grant (BA=BS=1), returns halt_ack.
- Executes blitter reads (latency-compensated) and nibble-masked writes, using read-modify-write for partial nibbles; returns blt_ack aligned to the E-phase enable.

Parameters:
- RD_LATENCY, 1, clk cycles from mem_rd pulse to mem_rdata valid (1..7).
- HALT_SYNC, 1, 1 = require BA/BS grant seen on two consecutive en_e_n cycles before halt_ack; 0 = one.

Ports:
- clk  in  1  system clock
- rst_n  in  1  Synchronous reset, active-low.
- en_e_n  in  1  E-phase clock enable (blitter advances only when high)
- halt  in  1  blitter bus request
- halt_ack  out  1  bus granted to blitter
- cpu_halt_n  out  1  to 6809 HALT pin, active-low
- cpu_ba  in  1  6809 bus available
- cpu_bs  in  1  6809 bus status
- blt_rd  in  1  blitter read request
- blt_wr  in  1  blitter write request
- blt_address  in  16  blitter address
- blt_wdata  in  8  blitter write data
- blt_nibble_en  in  2  [1]=upper, [0]=lower nibble write enable
- blt_ack  out  1  access complete
- blt_rdata  out  8  read data to blitter
- mem_addr  out  16  RAM address
- mem_rd  out  1  one-clk read strobe
- mem_wr  out  1  one-clk write strobe
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; cpu_halt_n=1, halt_ack=0, blt_ack=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, blt_rdata=0, grant counter=0. Reset mid-access aborts; no strobe issued after the reset edge.
- States: IDLE, HALT_REQ, OWNED, RD, RD_WAIT, WR, ACK.
- IDLE: halt=1 -> cpu_halt_n=0, go HALT_REQ.
- HALT_REQ: on each en_e_n cycle, if cpu_ba&&cpu_bs, increment grant count, else clear it. Count reaches 1+HALT_SYNC -> halt_ack=1, go OWNED. halt=0 here -> cpu_halt_n=1, go IDLE.
- OWNED: halt=0 -> halt_ack=0, cpu_halt_n=1 next clk, go IDLE. blt_rd (priority if both rd and wr) -> latch address, go RD. blt_wr: nibble_en=11 -> WR with mem_wdata=blt_wdata; nibble_en=00 -> ACK with no memory cycle; 01/10 -> RD (read-modify-write).
- RD: mem_rd=1 for exactly one clk, mem_addr=latched address; go RD_WAIT.
- RD_WAIT: count RD_LATENCY clks after the strobe, then sample mem_rdata. For a read: blt_rdata<=mem_rdata, go ACK. For RMW: merge enabled nibbles from blt_wdata with the other nibbles from mem_rdata into mem_wdata, go WR.
- WR: mem_wr=1 for exactly one clk; go ACK.
- ACK: blt_ack=1 and held until the first clk with en_e_n=1 (inclusive). It drops the following clk, returning to OWNED. A request still asserted after the drop is a new access only if the blitter re-presents it. Because the blitter state changes on that en_e_n edge, the block waits one clk in OWNED before re-sampling blt_rd/blt_wr.
- halt_ack stays 1 through all access states. halt=0 during an access is illegal; the access completes, then the block releases.
- blt_rdata holds its value until the next read completes.
- cpu_ba/cpu_bs changes while OWNED are ignored.
- Address and data are latched at request acceptance. Later input changes do not affect the cycle in flight.

Test Plan:
- halt=1; BA/BS=1 from the 2nd en_e_n (HALT_SYNC=1) -> cpu_halt_n=0 next clk; halt_ack=1 after the 2nd qualifying en_e_n; halt=0 -> halt_ack=0, cpu_halt_n=1 next clk.
- Owned, blt_rd addr 16'h9A3C, RAM holds 8'h5E, RD_LATENCY=2 -> one mem_rd at 9A3C; blt_rdata=8'h5E; blt_ack high until the next en_e_n, then low.
- Owned, blt_wr addr 16'h0010, data 8'hA7, nibble_en=11 -> single mem_wr with mem_wdata=8'hA7, no mem_rd.
- blt_wr data 8'hA7, nibble_en=10, RAM holds 8'h3C -> mem_rd, then mem_wr with 8'hAC; with nibble_en=01 -> 8'h37.
- nibble_en=00 write -> blt_ack with zero mem_rd/mem_wr strobes; simultaneous blt_rd+blt_wr -> read executed only.
- rst_n=0 asserted in RD_WAIT -> next clk all outputs at reset values, no mem_wr, cpu_halt_n=1.
